// File: rtl/issue_queue.sv
// Per-unit out-of-order issue queue: collapsing storage, tag wakeup,
// oldest-ready select with a registered one-cycle issue pulse.
module issue_queue #(
    parameter int DEPTH         = 8,
    parameter int PHY_WIDTH     = 6,
    parameter int ROB_WIDTH     = 5,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int NUM_WAKE      = 3,
    parameter int COUNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [ROB_WIDTH-1:0]          dispatch_rob_id,
    input  logic [PHY_WIDTH-1:0]          dispatch_rs1_phy,
    input  logic [PHY_WIDTH-1:0]          dispatch_rs2_phy,
    input  logic [PHY_WIDTH-1:0]          dispatch_rd_phy,
    input  logic                          dispatch_rs1_rdy,
    input  logic                          dispatch_rs2_rdy,
    input  logic [PAYLOAD_WIDTH-1:0]      dispatch_payload,
    input  logic [NUM_WAKE-1:0]           wake_valid,
    input  logic [NUM_WAKE*PHY_WIDTH-1:0] wake_tag,
    input  logic                          busy,
    output logic                          issue_valid,
    output logic [ROB_WIDTH-1:0]          issue_rob_id,
    output logic [PHY_WIDTH-1:0]          issue_rs1_phy,
    output logic [PHY_WIDTH-1:0]          issue_rs2_phy,
    output logic [PHY_WIDTH-1:0]          issue_rd_phy,
    output logic [PAYLOAD_WIDTH-1:0]      issue_payload,
    output logic [COUNT_W-1:0]            count
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ROB_WIDTH-1:0]     rob;
        logic [PHY_WIDTH-1:0]     rs1;
        logic [PHY_WIDTH-1:0]     rs2;
        logic [PHY_WIDTH-1:0]     rd;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic                     r1;
        logic                     r2;
    } entry_t;

    entry_t             q      [DEPTH];
    entry_t             q_next [DEPTH];
    logic [DEPTH-1:0]   rdy;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   wr;
    logic               fire;
    logic               accept;
    logic [COUNT_W-1:0] count_next;
    entry_t             sel_e;

    function automatic logic hit(
        input logic [PHY_WIDTH-1:0]          tag,
        input logic [NUM_WAKE-1:0]           v,
        input logic [NUM_WAKE*PHY_WIDTH-1:0] t
    );
        hit = 1'b0;
        for (int p = 0; p < NUM_WAKE; p++) begin
            if (v[p] && t[p*PHY_WIDTH +: PHY_WIDTH] == tag) begin
                hit = 1'b1;
            end
        end
    endfunction

    assign dispatch_ready = (count < COUNT_W'(DEPTH));
    assign accept = dispatch_valid & dispatch_ready & ~flush;

    // Readiness uses registered bits only; wakeups land next cycle.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = (COUNT_W'(i) < count) & q[i].r1 & q[i].r2;
        end
    end

    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    assign fire  = ~busy & ~flush & (|rdy);
    assign sel_e = q[sel];
    assign wr    = IDX_W'(count - COUNT_W'(fire));

    always_comb begin
        entry_t e;
        entry_t d;
        for (int j = 0; j < DEPTH; j++) begin
            e = q[j];
            if (fire && IDX_W'(j) >= sel) begin
                e = q[(j < DEPTH - 1) ? j + 1 : j];
            end
            e.r1 = e.r1 | hit(e.rs1, wake_valid, wake_tag);
            e.r2 = e.r2 | hit(e.rs2, wake_valid, wake_tag);
            q_next[j] = e;
        end
        d.rob     = dispatch_rob_id;
        d.rs1     = dispatch_rs1_phy;
        d.rs2     = dispatch_rs2_phy;
        d.rd      = dispatch_rd_phy;
        d.payload = dispatch_payload;
        d.r1 = dispatch_rs1_rdy
             | hit(dispatch_rs1_phy, wake_valid, wake_tag);
        d.r2 = dispatch_rs2_rdy
             | hit(dispatch_rs2_phy, wake_valid, wake_tag);
        if (accept) begin
            q_next[wr] = d;
        end
    end

    always_comb begin
        count_next = count + COUNT_W'(accept) - COUNT_W'(fire);
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            issue_valid   <= 1'b0;
            issue_rob_id  <= '0;
            issue_rs1_phy <= '0;
            issue_rs2_phy <= '0;
            issue_rd_phy  <= '0;
            issue_payload <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            count       <= count_next;
            issue_valid <= fire;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_next[i];
            end
            if (fire) begin
                issue_rob_id  <= sel_e.rob;
                issue_rs1_phy <= sel_e.rs1;
                issue_rs2_phy <= sel_e.rs2;
                issue_rd_phy  <= sel_e.rd;
                issue_payload <= sel_e.payload;
            end
        end
    end

endmodule
